// File: rtl/axi_sram_slave_if.sv
// AXI3 bus bundle between the SRAM-to-AXI bridge and the on-chip RAM slave.
interface axi_sram_slave_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI3 slave RAM behind the core's SRAM-to-AXI bridge.
// One transaction at a time; FIXED/INCR bursts up to 16 beats.
module axi_sram_slave #(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             resetn,
    axi_sram_slave_if.slave  bus
);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {IDLE, RD, WD, WB} state_t;

    state_t      state;
    logic        pref_rd;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [7:0]  beat;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [1:0]  err;
    logic        len_bad;

    logic [31:0] mem [2**ADDR_W];

    logic [ADDR_W-1:0] widx;
    logic [31:0]       step;
    logic [31:0]       next_addr;
    logic              ar_hs, aw_hs, r_hs, w_hs, b_hs;
    logic              unused;

    function automatic logic hit(input logic [31:0] a);
        return a[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2];
    endfunction

    function automatic logic [1:0] classify(
        input logic [31:0] a,
        input logic [7:0]  l,
        input logic [2:0]  s,
        input logic [1:0]  b
    );
        if (!hit(a))
            return DECERR;
        if (s > 3'd2 || l > 8'd15 || b[1])
            return SLVERR;
        return OKAY;
    endfunction

    assign widx   = addr[ADDR_W+1:2];
    assign unused = ^bus.wid;

    // INCR aligns down to the beat size before stepping
    always_comb begin
        step      = 32'd1 << size;
        next_addr = addr;
        if (burst == 2'b01)
            next_addr = (addr & ~(step - 32'd1)) + step;
    end

    assign bus.arready = resetn & (state == IDLE) & bus.arvalid
                       & (pref_rd | ~bus.awvalid);
    assign bus.awready = resetn & (state == IDLE) & bus.awvalid
                       & (~pref_rd | ~bus.arvalid);

    assign bus.rvalid = (state == RD);
    assign bus.rid    = bus.rvalid ? id : 4'd0;
    assign bus.rresp  = bus.rvalid ? err : OKAY;
    assign bus.rlast  = bus.rvalid & (beat == len);
    assign bus.rdata  = (bus.rvalid && err == OKAY) ? mem[widx] : 32'd0;

    assign bus.wready = (state == WD);

    assign bus.bvalid = (state == WB);
    assign bus.bid    = bus.bvalid ? id : 4'd0;
    assign bus.bresp  = bus.bvalid ? err : OKAY;

    assign ar_hs = bus.arvalid & bus.arready;
    assign aw_hs = bus.awvalid & bus.awready;
    assign r_hs  = bus.rvalid & bus.rready;
    assign w_hs  = bus.wvalid & bus.wready;
    assign b_hs  = bus.bvalid & bus.bready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            pref_rd <= 1'b1;
            id      <= '0;
            addr    <= '0;
            len     <= '0;
            beat    <= '0;
            size    <= '0;
            burst   <= '0;
            err     <= OKAY;
            len_bad <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    beat    <= '0;
                    len_bad <= 1'b0;
                    if (ar_hs) begin
                        state   <= RD;
                        pref_rd <= 1'b0;
                        id      <= bus.arid;
                        addr    <= bus.araddr;
                        len     <= bus.arlen;
                        size    <= bus.arsize;
                        burst   <= bus.arburst;
                        err     <= classify(bus.araddr, bus.arlen,
                                            bus.arsize, bus.arburst);
                    end else if (aw_hs) begin
                        state   <= WD;
                        pref_rd <= 1'b1;
                        id      <= bus.awid;
                        addr    <= bus.awaddr;
                        len     <= bus.awlen;
                        size    <= bus.awsize;
                        burst   <= bus.awburst;
                        err     <= classify(bus.awaddr, bus.awlen,
                                            bus.awsize, bus.awburst);
                    end
                end
                RD: begin
                    if (r_hs) begin
                        if (beat == len) begin
                            state <= IDLE;
                        end else begin
                            beat <= beat + 8'd1;
                            addr <= next_addr;
                            if (!hit(next_addr))
                                err <= DECERR;
                        end
                    end
                end
                WD: begin
                    if (w_hs) begin
                        if (bus.wlast) begin
                            state <= WB;
                            if (err == OKAY && (len_bad || beat != len))
                                err <= SLVERR;
                        end else begin
                            // wlast missing on the final beat
                            if (beat == len)
                                len_bad <= 1'b1;
                            if (beat != 8'hff)
                                beat <= beat + 8'd1;
                            addr <= next_addr;
                            if (!hit(next_addr))
                                err <= DECERR;
                        end
                    end
                end
                WB: begin
                    if (b_hs)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage has no reset; beats past awlen are dropped
    always_ff @(posedge clk) begin
        if (w_hs && err == OKAY && beat <= len) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.wstrb[i])
                    mem[widx][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: expected R/B beats are queued
// when a transaction is issued and popped as the slave returns them.
module tb_axi_sram_slave;
    logic clk = 1'b0;
    logic resetn = 1'b0;

    always #5 clk = ~clk;

    axi_sram_slave_if bus();

    axi_sram_slave #(
        .ADDR_W   (12),
        .BASE_ADDR(32'h0000_0000)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } rexp_t;

    typedef struct packed {
        logic [1:0] resp;
        logic [3:0] id;
    } bexp_t;

    rexp_t rq[$];
    bexp_t bq[$];
    int checks = 0;
    int failures = 0;

    task automatic idle_inputs();
        bus.arid = 0; bus.araddr = 0; bus.arlen = 0;
        bus.arsize = 0; bus.arburst = 0; bus.arvalid = 0;
        bus.rready = 0;
        bus.awid = 0; bus.awaddr = 0; bus.awlen = 0;
        bus.awsize = 0; bus.awburst = 0; bus.awvalid = 0;
        bus.wid = 0; bus.wdata = 0; bus.wstrb = 0;
        bus.wlast = 0; bus.wvalid = 0;
        bus.bready = 0;
    endtask

    task automatic push_r(input logic [31:0] d, input logic [1:0] r,
                          input logic l, input logic [3:0] i);
        rexp_t e;
        e.data = d; e.resp = r; e.last = l; e.id = i;
        rq.push_back(e);
    endtask

    task automatic push_b(input logic [1:0] r, input logic [3:0] i);
        bexp_t e;
        e.resp = r; e.id = i;
        bq.push_back(e);
    endtask

    task automatic set_ar(input logic [3:0] i, input logic [31:0] a,
                          input logic [7:0] l, input logic [2:0] s,
                          input logic [1:0] b);
        bus.arid = i; bus.araddr = a; bus.arlen = l;
        bus.arsize = s; bus.arburst = b; bus.arvalid = 1;
    endtask

    task automatic set_aw(input logic [3:0] i, input logic [31:0] a,
                          input logic [7:0] l, input logic [2:0] s,
                          input logic [1:0] b);
        bus.awid = i; bus.awaddr = a; bus.awlen = l;
        bus.awsize = s; bus.awburst = b; bus.awvalid = 1;
    endtask

    task automatic ar_send(input logic [3:0] i, input logic [31:0] a,
                           input logic [7:0] l, input logic [2:0] s,
                           input logic [1:0] b);
        bit done = 0;
        set_ar(i, a, l, s, b);
        for (int n = 0; n < 50 && !done; n++) begin
            #1;
            if (bus.arready) done = 1;
            @(negedge clk);
        end
        bus.arvalid = 0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL ar_timeout addr=%h arready=%b required=1", a, bus.arready);
        end
    endtask

    task automatic aw_send(input logic [3:0] i, input logic [31:0] a,
                           input logic [7:0] l, input logic [2:0] s,
                           input logic [1:0] b);
        bit done = 0;
        set_aw(i, a, l, s, b);
        for (int n = 0; n < 50 && !done; n++) begin
            #1;
            if (bus.awready) done = 1;
            @(negedge clk);
        end
        bus.awvalid = 0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL aw_timeout addr=%h awready=%b required=1", a, bus.awready);
        end
    endtask

    task automatic w_send(input logic [31:0] d, input logic [3:0] st,
                          input logic l);
        bit done = 0;
        bus.wdata = d; bus.wstrb = st; bus.wlast = l; bus.wvalid = 1;
        for (int n = 0; n < 50 && !done; n++) begin
            #1;
            if (bus.wready) done = 1;
            @(negedge clk);
        end
        bus.wvalid = 0;
        bus.wlast = 0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL w_timeout data=%h wready=%b required=1", d, bus.wready);
        end
    endtask

    task automatic b_drain();
        bexp_t e;
        bit done = 0;
        bus.bready = 1;
        for (int n = 0; n < 50 && !done; n++) begin
            #1;
            if (bus.bvalid) begin
                e = bq.pop_front();
                checks++;
                if (bus.bresp !== e.resp || bus.bid !== e.id) begin
                    failures++;
                    $display("FAIL b_resp got resp=%b id=%h required resp=%b id=%h",
                             bus.bresp, bus.bid, e.resp, e.id);
                end
                done = 1;
            end
            @(negedge clk);
        end
        bus.bready = 0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL b_timeout bvalid=%b required=1", bus.bvalid);
        end
    endtask

    // toggle=1 drives rready 1,0,1,0...; stalled beats are checked for stability
    task automatic r_drain(input bit toggle);
        rexp_t e;
        int n = 0;
        while (rq.size() > 0 && n < 200) begin
            bus.rready = toggle ? (n % 2 == 0) : 1'b1;
            #1;
            if (bus.rvalid) begin
                e = rq[0];
                checks++;
                if (bus.rdata !== e.data || bus.rresp !== e.resp ||
                    bus.rlast !== e.last || bus.rid !== e.id) begin
                    failures++;
                    $display("FAIL r_beat rready=%b got data=%h resp=%b last=%b id=%h required data=%h resp=%b last=%b id=%h",
                             bus.rready, bus.rdata, bus.rresp, bus.rlast, bus.rid,
                             e.data, e.resp, e.last, e.id);
                end
                if (bus.rready) void'(rq.pop_front());
            end
            @(negedge clk);
            n++;
        end
        bus.rready = 0;
        checks++;
        if (rq.size() != 0) begin
            failures++;
            $display("FAIL r_timeout beats_left=%0d required=0", rq.size());
        end
        rq.delete();
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.arvalid = 1;
        bus.awvalid = 1;
        bus.wvalid = 1;
        #12;
        checks++;
        if (bus.arready !== 1'b0 || bus.awready !== 1'b0 || bus.wready !== 1'b0 ||
            bus.rvalid !== 1'b0 || bus.bvalid !== 1'b0 || bus.rdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs got arready=%b awready=%b wready=%b rvalid=%b bvalid=%b rdata=%h required all 0",
                     bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid, bus.rdata);
        end
        idle_inputs();
        @(negedge clk);
        resetn = 1;
        @(negedge clk);
    endtask

    task automatic test_arbitration();
        set_ar(4'h1, 32'h8000_0000, 8'd0, 3'd2, 2'b01);
        set_aw(4'h2, 32'h40, 8'd0, 3'd2, 2'b01);
        #1;
        checks++;
        if (bus.arready !== 1'b1 || bus.awready !== 1'b0) begin
            failures++;
            $display("FAIL arb_first got arready=%b awready=%b required arready=1 awready=0",
                     bus.arready, bus.awready);
        end
        push_r(32'd0, 2'b11, 1'b1, 4'h1);
        @(negedge clk);
        bus.arvalid = 0;
        bus.awvalid = 0;
        r_drain(1'b0);
        set_ar(4'h3, 32'h40, 8'd0, 3'd2, 2'b01);
        set_aw(4'h2, 32'h40, 8'd0, 3'd2, 2'b01);
        #1;
        checks++;
        if (bus.arready !== 1'b0 || bus.awready !== 1'b1) begin
            failures++;
            $display("FAIL arb_second got arready=%b awready=%b required arready=0 awready=1",
                     bus.arready, bus.awready);
        end
        push_b(2'b00, 4'h2);
        @(negedge clk);
        bus.arvalid = 0;
        bus.awvalid = 0;
        w_send(32'h0BAD_F00D, 4'hF, 1'b1);
        b_drain();
        push_r(32'h0BAD_F00D, 2'b00, 1'b1, 4'h3);
        ar_send(4'h3, 32'h40, 8'd0, 3'd2, 2'b01);
        r_drain(1'b0);
    endtask

    task automatic test_single_write();
        push_b(2'b00, 4'h3);
        aw_send(4'h3, 32'h10, 8'd0, 3'd2, 2'b01);
        w_send(32'hDEAD_BEEF, 4'hF, 1'b1);
        b_drain();
        push_r(32'hDEAD_BEEF, 2'b00, 1'b1, 4'h5);
        ar_send(4'h5, 32'h10, 8'd0, 3'd2, 2'b01);
        r_drain(1'b0);
    endtask

    task automatic test_strobe();
        push_b(2'b00, 4'h4);
        aw_send(4'h4, 32'h10, 8'd0, 3'd2, 2'b01);
        w_send(32'h1122_3344, 4'b0100, 1'b1);
        b_drain();
        push_r(32'hDE22_BEEF, 2'b00, 1'b1, 4'h6);
        ar_send(4'h6, 32'h10, 8'd0, 3'd2, 2'b01);
        r_drain(1'b0);
    endtask

    task automatic test_incr_burst();
        push_b(2'b00, 4'h6);
        aw_send(4'h6, 32'h20, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++)
            w_send(32'hA000_0000 + i, 4'hF, i == 3);
        b_drain();
        for (int i = 0; i < 4; i++)
            push_r(32'hA000_0000 + i, 2'b00, i == 3, 4'h7);
        ar_send(4'h7, 32'h20, 8'd3, 3'd2, 2'b01);
        r_drain(1'b1);
    endtask

    task automatic test_errors();
        bus.wvalid = 1;
        #1;
        checks++;
        if (bus.wready !== 1'b0) begin
            failures++;
            $display("FAIL w_before_aw got wready=%b required=0", bus.wready);
        end
        bus.wvalid = 0;
        @(negedge clk);
        push_r(32'd0, 2'b11, 1'b1, 4'h8);
        ar_send(4'h8, 32'h8000_0000, 8'd0, 3'd2, 2'b01);
        r_drain(1'b0);
        push_r(32'd0, 2'b10, 1'b1, 4'h9);
        ar_send(4'h9, 32'h10, 8'd0, 3'd3, 2'b01);
        r_drain(1'b0);
        push_b(2'b10, 4'hA);
        aw_send(4'hA, 32'h10, 8'd0, 3'd2, 2'b10);
        w_send(32'hCAFE_F00D, 4'hF, 1'b1);
        b_drain();
        push_r(32'hDE22_BEEF, 2'b00, 1'b1, 4'hB);
        ar_send(4'hB, 32'h10, 8'd0, 3'd2, 2'b01);
        r_drain(1'b0);
    endtask

    task automatic test_window_edge();
        push_b(2'b00, 4'h1);
        aw_send(4'h1, 32'h3FFC, 8'd0, 3'd2, 2'b01);
        w_send(32'h55AA_55AA, 4'hF, 1'b1);
        b_drain();
        push_r(32'h55AA_55AA, 2'b00, 1'b0, 4'h2);
        push_r(32'd0, 2'b11, 1'b1, 4'h2);
        ar_send(4'h2, 32'h3FFC, 8'd1, 3'd2, 2'b01);
        r_drain(1'b0);
    endtask

    task automatic test_wlast_early();
        push_b(2'b10, 4'hC);
        aw_send(4'hC, 32'h60, 8'd3, 3'd2, 2'b01);
        w_send(32'h1111_1111, 4'hF, 1'b0);
        w_send(32'h2222_2222, 4'hF, 1'b1);
        b_drain();
        push_r(32'h1111_1111, 2'b00, 1'b0, 4'hD);
        push_r(32'h2222_2222, 2'b00, 1'b1, 4'hD);
        ar_send(4'hD, 32'h60, 8'd1, 3'd2, 2'b01);
        r_drain(1'b0);
    endtask

    task automatic test_reset_mid_burst();
        ar_send(4'h9, 32'h20, 8'd3, 3'd2, 2'b01);
        checks++;
        if (bus.rvalid !== 1'b1) begin
            failures++;
            $display("FAIL mid_rvalid_before got rvalid=%b required=1", bus.rvalid);
        end
        #1;
        resetn = 0;
        set_ar(4'hE, 32'h20, 8'd0, 3'd2, 2'b01);
        #1;
        checks++;
        if (bus.rvalid !== 1'b0 || bus.arready !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got rvalid=%b arready=%b required 0 0",
                     bus.rvalid, bus.arready);
        end
        @(negedge clk);
        resetn = 1;
        #1;
        checks++;
        if (bus.arready !== 1'b1) begin
            failures++;
            $display("FAIL arready_after_reset got=%b required=1", bus.arready);
        end
        push_r(32'hA000_0000, 2'b00, 1'b1, 4'hE);
        @(negedge clk);
        bus.arvalid = 0;
        r_drain(1'b0);
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_single_write();
        test_strobe();
        test_incr_burst();
        test_errors();
        test_window_edge();
        test_wlast_early();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI3 slave RAM that sits directly downstream of the CPU's SRAM-like-to-AXI bridge.
- Serves the bridge's AR/R and AW/W/B channels from an internal word-organised memory, so the core can run end-to-end in simulation without the SoC crossbar.
- Handles one transaction at a time.
- Supports single-beat and short INCR/FIXED bursts, byte strobes, and error responses.

Parameters:
- ADDR_W, 12, word-address width; memory holds 2**ADDR_W 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte base address. A hit requires addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2].

Ports:
- clk  in  1  Single clock; all logic is rising-edge.
- resetn  in  1  Reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- arid, awid  in  4  Read/write transaction ID.
- araddr, awaddr  in  32  Byte start address.
- arlen, awlen  in  8  Beats minus 1; only 0..15 accepted.
- arsize, awsize  in  3  log2 bytes per beat.
- arburst, awburst  in  2  00 FIXED, 01 INCR, others unsupported.
- arvalid, awvalid  in  1  Address valid.
- arready, awready  out  1  Address accept.
- rid  out  4  Equals the latched arid.
- rdata  out  32  Read beat data.
- rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR.
- rlast, rvalid  out  1  Final beat flag; read data valid.
- rready  in  1  Master accepts beat.
- wid  in  4  Ignored.
- wdata  in  32  Write beat data.
- wstrb  in  4  Byte enables.
- wlast, wvalid  in  1  Final write beat flag; write data valid.
- wready  out  1  Write beat accept.
- bid  out  4  Equals the latched awid.
- bresp  out  2  Write response; same encoding as rresp.
- bvalid  out  1  Write response valid.
- bready  in  1  Master accepts response.

Behaviour:
- Reset: FSM=IDLE, pref_rd=1, beat counters=0. All outputs are 0 while resetn is low, including arready and awready, which are gated by resetn. Memory contents are not reset. An assertion mid-burst abandons the transaction with no response.
- FSM states:
  - IDLE -> RD on an AR handshake.
  - IDLE -> WD on an AW handshake.
  - RD -> IDLE on an R handshake with rlast=1.
  - WD -> WB on a W handshake with wlast=1.
  - WB -> IDLE on a B handshake.
- Address-channel ready rules (combinational):
  - arready = IDLE & arvalid & (pref_rd | ~awvalid).
  - awready = IDLE & awvalid & (~pref_rd | ~arvalid).
  - The two never assert together.
- Fairness: on each grant, pref_rd is set to the opposite type, so simultaneous requests alternate, read first after reset.
- Latch on address handshake: id, addr, len, size, burst, and err.
  - err = DECERR on address miss.
  - Otherwise err = SLVERR if size>2, len>15, or burst is not FIXED/INCR.
  - Otherwise err = OKAY.
  - Requests with len>15 are still accepted, then errored.
- Read:
  - rvalid rises the cycle after the AR handshake. No bubbles between beats when rready is held high.
  - rdata = mem[addr[ADDR_W+1:2]], full word, independent of size. rdata=0 when err!=OKAY.
  - rresp = err on every beat. rlast=1 on beat len.
  - rvalid, rdata, rresp, and rlast are held stable while rready=0.
- Write:
  - wready = 1 throughout WD; 0 in all other states (W never accepted before AW).
  - Each W handshake with err==OKAY writes the bytes of wdata enabled by wstrb into mem at the current word address. With err!=OKAY, nothing is written.
- Address advance per beat:
  - FIXED: address unchanged.
  - INCR: next = (addr & ~(2**size-1)) + 2**size.
  - An advance past the top of the window sets err=DECERR for the remaining beats and for the response.
- Write-length check: if wlast arrives on a beat other than awlen, or is absent on beat awlen, then bresp=SLVERR. The transaction still ends on the wlast beat, and extra beats past awlen are not written.
- Write response: bvalid rises the cycle after the wlast handshake, with bid = latched awid and bresp = err, held until bready.
- Read-after-write visibility: a read accepted after a B handshake returns the written data.

Test Plan:
- Single write: awaddr=0x10, wdata=0xDEADBEEF, wstrb=F, len 0. Then a read of 0x10 -> rdata=0xDEADBEEF, rresp=00, rlast=1, rid=arid.
- Byte strobe: write 0x11223344 with wstrb=0100 over 0xDEADBEEF at 0x10 -> readback 0xDE22BEEF.
- INCR read burst: arlen=3, arsize=2, araddr=0x20, with rready toggling 1,0,1,0. Four beats from words 8..11, stable while stalled, rlast only on the fourth beat.
- Simultaneous arvalid and awvalid after reset -> read granted first; the next simultaneous pair -> write granted.
- araddr outside the window -> rresp=11, rdata=0. arsize=3 -> rresp=10. awburst=10 -> bresp=10 with memory unchanged.
- wlast asserted on beat 1 of awlen=3 -> bresp=10, beats 0 and 1 written. resetn pulled low mid-read-burst -> rvalid=0 immediately, arready returns after release.
